// File: rtl/gpio_led_channels.sv
// gpio_led_channels
//   Per-channel GPIO input conditioning and LED drive for the iCEBreaker.
//   Each raw GPIO input is synchronised, debounced and edge-detected. The
//   channel's LED is then driven in one of four modes:
//   pass, toggle, blink or pulse-stretch.
//
// Ports
//   sys_clk     in   1            system clock (12 MHz board clock)
//   sys_rst     in   1            synchronous active-high reset; clears every register
//   gpio_in     in   CHANNELS     raw asynchronous GPIO inputs
//   mode        in   2*CHANNELS   per-channel mode, bits [2i+1:2i] for channel i
//                                 (00 pass, 01 toggle, 10 blink, 11 stretch)
//   led_out     out  CHANNELS     registered LED drive
//   gpio_level  out  CHANNELS     debounced stable level
//   rise_pulse  out  CHANNELS     one-cycle pulse on a stable 0->1 transition
//   fall_pulse  out  CHANNELS     one-cycle pulse on a stable 1->0 transition
//   edge_count  out  8*CHANNELS   rising-edge counters, 8 bits per channel
//                                 (present only when GPIO_EDGE_COUNT_EN is defined)
//
// Optional feature macro: GPIO_EDGE_COUNT_EN
module gpio_led_channels #(
  parameter int CHANNELS          = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 12000,
  parameter int BLINK_HALF_PERIOD = 3000000,
  parameter int STRETCH_CYCLES    = 1200000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [CHANNELS-1:0]     gpio_in,
  input  logic [2*CHANNELS-1:0]   mode,
  output logic [CHANNELS-1:0]     led_out,
  output logic [CHANNELS-1:0]     gpio_level,
  output logic [CHANNELS-1:0]     rise_pulse,
  output logic [CHANNELS-1:0]     fall_pulse
`ifdef GPIO_EDGE_COUNT_EN
  ,
  output logic [8*CHANNELS-1:0]   edge_count
`endif
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam int ST_W = $clog2(STRETCH_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_PERIOD - 1);
  localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);

  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_STRETCH = 2'b11
  } led_mode_e;

  function automatic logic [ST_W-1:0] sat_dec(input logic [ST_W-1:0] v);
    return (v == '0) ? '0 : v - ST_ONE;
  endfunction

  // Stage p0: synchroniser chain; the last stage is the channel's sync value
  logic [CHANNELS-1:0] sync_p0 [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_last;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
    end else begin
      sync_p0[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
    end
  end

  assign sync_last = sync_p0[SYNC_STAGES-1];

  // Stage p1: debounce; any cycle of agreement with the stable level restarts the count
  logic [DB_W-1:0]     db_cnt_p1 [CHANNELS];
  logic [CHANNELS-1:0] stable_p1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stable_p1 <= '0;
      for (int c = 0; c < CHANNELS; c++) db_cnt_p1[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sync_last[c] == stable_p1[c]) begin
          db_cnt_p1[c] <= '0;
        end else if (db_cnt_p1[c] == DB_LAST) begin
          stable_p1[c] <= sync_last[c];
          db_cnt_p1[c] <= '0;
        end else begin
          db_cnt_p1[c] <= db_cnt_p1[c] + DB_ONE;
        end
      end
    end
  end

  // Stage p2: edge detect against the delayed level, plus toggle/stretch state and blink prescaler
  logic [CHANNELS-1:0] stable_p2;
  logic [CHANNELS-1:0] toggle_p2;
  logic [ST_W-1:0]     stretch_p2 [CHANNELS];
  logic [BL_W-1:0]     blink_cnt_p2;
  logic                blink_phase_p2;

  assign gpio_level = stable_p1;
  assign rise_pulse = stable_p1 & ~stable_p2;
  assign fall_pulse = ~stable_p1 & stable_p2;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stable_p2 <= '0;
      toggle_p2 <= '0;
      for (int c = 0; c < CHANNELS; c++) stretch_p2[c] <= '0;
    end else begin
      stable_p2 <= stable_p1;
      toggle_p2 <= toggle_p2 ^ rise_pulse;
      for (int c = 0; c < CHANNELS; c++) begin
        // A retrigger reloads the full on-time rather than extending it
        stretch_p2[c] <= rise_pulse[c] ? ST_LOAD : sat_dec(stretch_p2[c]);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      blink_cnt_p2   <= '0;
      blink_phase_p2 <= 1'b0;
    end else if (blink_cnt_p2 == BL_LAST) begin
      blink_cnt_p2   <= '0;
      blink_phase_p2 <= ~blink_phase_p2;
    end else begin
      blink_cnt_p2 <= blink_cnt_p2 + BL_ONE;
    end
  end

  // Stage p3: mode only selects the source, so switching modes never disturbs channel state
  logic [CHANNELS-1:0] led_sel;

  always_comb begin
    led_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (led_mode_e'(mode[2*c +: 2]))
        MODE_PASS:    led_sel[c] = stable_p1[c];
        MODE_TOGGLE:  led_sel[c] = toggle_p2[c];
        MODE_BLINK:   led_sel[c] = stable_p1[c] & blink_phase_p2;
        MODE_STRETCH: led_sel[c] = (stretch_p2[c] != '0);
        default:      led_sel[c] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) led_out <= '0;
    else         led_out <= led_sel;
  end

`ifdef GPIO_EDGE_COUNT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      edge_count <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (rise_pulse[c]) edge_count[8*c +: 8] <= edge_count[8*c +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gpio_led_channels.sv
// tb_gpio_led_channels
//   Self-checking bench for gpio_led_channels with small parameters
//   (2 channels, 2 sync stages, debounce 4, blink half-period 8, stretch 10).
//   The reference model describes each output directly from the input history:
//   a level is accepted once the synchronised input has disagreed with it for
//   DEB consecutive samples. Blink phase is the elapsed-cycle count divided by
//   the half-period. Toggle is the parity of rises. Stretch is "fewer than STR
//   cycles since the last rise".
`timescale 1ns/1ps
module tb_gpio_led_channels;

  localparam int CH    = 2;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int STR   = 10;
  localparam int HN    = SYNC + DEB;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [CH-1:0]     gpio_in = '0;
  logic [2*CH-1:0]   mode    = '0;
  logic [CH-1:0]     led_out, gpio_level, rise_pulse, fall_pulse;
`ifdef GPIO_EDGE_COUNT_EN
  logic [8*CH-1:0]   edge_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  gpio_led_channels #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .BLINK_HALF_PERIOD(BLINK), .STRETCH_CYCLES(STR)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gpio_in(gpio_in), .mode(mode),
    .led_out(led_out), .gpio_level(gpio_level),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
`ifdef GPIO_EDGE_COUNT_EN
    , .edge_count(edge_count)
`endif
  );

  // Reference model. mh[0] is the input sampled at the latest edge.
  logic [CH-1:0] mh [HN];
  logic [CH-1:0] m_stable = '0, m_prev = '0, m_tog = '0, m_led = '0, m_rise;
  logic          m_phase;
  logic          m_all;
  int            m_t = 0, m_k = 0;
  int            m_last [CH];
  bit            m_has  [CH];
  int            m_ecnt [CH];

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < HN; i++) mh[i] = '0;
      m_stable = '0; m_prev = '0; m_tog = '0; m_led = '0;
      m_t = 0; m_k = 0;
      for (int c = 0; c < CH; c++) begin
        m_has[c] = 1'b0; m_last[c] = 0; m_ecnt[c] = 0;
      end
    end else begin
      m_rise  = m_stable & ~m_prev;
      m_phase = ((m_t / BLINK) % 2) == 1;
      for (int c = 0; c < CH; c++) begin
        case (mode[2*c +: 2])
          2'b00:   m_led[c] = m_stable[c];
          2'b01:   m_led[c] = m_tog[c];
          2'b10:   m_led[c] = m_stable[c] & m_phase;
          default: m_led[c] = m_has[c] && ((m_k - 1 - m_last[c]) < STR);
        endcase
      end
      for (int c = 0; c < CH; c++) begin
        if (m_rise[c]) begin
          m_tog[c]  = ~m_tog[c];
          m_last[c] = m_k;
          m_has[c]  = 1'b1;
          m_ecnt[c] = (m_ecnt[c] + 1) % 256;
        end
      end
      m_k++;
      m_t++;
      for (int i = HN - 1; i > 0; i--) mh[i] = mh[i-1];
      mh[0]  = gpio_in;
      m_prev = m_stable;
      for (int c = 0; c < CH; c++) begin
        m_all = 1'b1;
        for (int i = SYNC; i < HN; i++) if (mh[i][c] == m_stable[c]) m_all = 1'b0;
        if (m_all) m_stable[c] = ~m_stable[c];
      end
    end
  end

  logic [4*CH-1:0] exp_vec, act_vec;
  assign exp_vec = {m_led, m_stable, m_stable & ~m_prev, ~m_stable & m_prev};
  assign act_vec = {led_out, gpio_level, rise_pulse, fall_pulse};

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1; gpio_in = '0; mode = '0;
    tick(); tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    gpio_in = CH'($urandom);
    mode    = (2*CH)'($urandom);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (act_vec !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=0", k, act_vec);
      end
`ifdef GPIO_EDGE_COUNT_EN
      n_tests++;
      if (edge_count !== '0) begin
        n_fail++;
        $display("FAIL reset_edge_count got=%h want=0", edge_count);
      end
`endif
    end
    gpio_in = '0; mode = '0;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_pass_step();
    apply_reset();
    repeat (4) tick();
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL pass_model edge=%0d got=%h want=%h", k, act_vec, exp_vec);
      end
      if (k == 5) begin
        n_tests++;
        if (gpio_level !== 2'b00 || rise_pulse !== 2'b00) begin
          n_fail++;
          $display("FAIL pass_edge5 level=%b rise=%b want 00 00", gpio_level, rise_pulse);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (gpio_level !== 2'b01 || rise_pulse !== 2'b01 || led_out !== 2'b00) begin
          n_fail++;
          $display("FAIL pass_edge6 level=%b rise=%b led=%b want 01 01 00",
                   gpio_level, rise_pulse, led_out);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (gpio_level !== 2'b01 || rise_pulse !== 2'b00 || led_out !== 2'b01) begin
          n_fail++;
          $display("FAIL pass_edge7 level=%b rise=%b led=%b want 01 00 01",
                   gpio_level, rise_pulse, led_out);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [17:0] pat;
    pat = 18'b000000000001110111;
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      gpio_in[0] = pat[i];
      tick();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bounce_model i=%0d got=%h want=%h", i, act_vec, exp_vec);
      end
      n_tests++;
      if (gpio_level[0] !== 1'b0 || rise_pulse[0] !== 1'b0 || led_out[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_reject i=%0d level=%b rise=%b led=%b want 0 0 0",
                 i, gpio_level[0], rise_pulse[0], led_out[0]);
      end
    end
  endtask

  task automatic test_toggle();
    int falls;
    falls = 0;
    apply_reset();
    mode = 4'b0101;
    for (int p = 0; p < 2; p++) begin
      gpio_in[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick();
        n_tests++;
        if (act_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL toggle_model p=%0d got=%h want=%h", p, act_vec, exp_vec);
        end
      end
      n_tests++;
      if (led_out[0] !== (p == 0)) begin
        n_fail++;
        $display("FAIL toggle_after_press p=%0d led=%b want %0d", p, led_out[0], p == 0);
      end
      gpio_in[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (fall_pulse[0]) falls++;
        n_tests++;
        if (act_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL toggle_model_rel p=%0d got=%h want=%h", p, act_vec, exp_vec);
        end
      end
      n_tests++;
      if (led_out[0] !== (p == 0)) begin
        n_fail++;
        $display("FAIL toggle_after_release p=%0d led=%b want %0d", p, led_out[0], p == 0);
      end
    end
    n_tests++;
    if (falls != 2) begin
      n_fail++;
      $display("FAIL toggle_fall_count got=%0d want=2", falls);
    end
  endtask

  task automatic test_blink();
    logic prev;
    int   runlen, nchg, runs_ok;
    bit   fell, done;
    apply_reset();
    mode = 4'b0010;
    gpio_in[0] = 1'b1;
    prev = 1'b0; runlen = 0; nchg = 0; runs_ok = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL blink_model k=%0d got=%h want=%h", k, act_vec, exp_vec);
      end
      if (led_out[0] !== prev) begin
        if (nchg >= 1) begin
          n_tests++;
          if (runlen != BLINK) begin
            n_fail++;
            $display("FAIL blink_run k=%0d got=%0d want=%0d", k, runlen, BLINK);
          end else begin
            runs_ok++;
          end
        end
        nchg++;
        runlen = 1;
        prev = led_out[0];
      end else begin
        runlen++;
      end
    end
    n_tests++;
    if (runs_ok < 4) begin
      n_fail++;
      $display("FAIL blink_runs_seen got=%0d want>=4", runs_ok);
    end
    gpio_in[0] = 1'b0;
    fell = 1'b0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL blink_release_model got=%h want=%h", act_vec, exp_vec);
      end
      if (fell) begin
        n_tests++;
        if (led_out[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL blink_release_led got=%b want=0", led_out[0]);
        end
        done = 1'b1;
      end
      if (fall_pulse[0]) fell = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL blink_release_timeout no fall_pulse within 20 cycles");
    end
  endtask

  task automatic test_stretch();
    logic [39:0] pat;
    int ones;
    apply_reset();
    mode = 4'b0011;
    ones = 0;
    for (int k = 0; k < 30; k++) begin
      gpio_in[0] = (k < 4);
      tick();
      if (led_out[0]) ones++;
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL stretch_model k=%0d got=%h want=%h", k, act_vec, exp_vec);
      end
    end
    n_tests++;
    if (ones != STR) begin
      n_fail++;
      $display("FAIL stretch_single on_cycles=%0d want=%0d", ones, STR);
    end
    // Two presses whose rises are 8 cycles apart, inside the first stretch window
    apply_reset();
    mode = 4'b0011;
    pat  = 40'h0000000F0F;
    ones = 0;
    for (int k = 0; k < 40; k++) begin
      gpio_in[0] = pat[k];
      tick();
      if (led_out[0]) ones++;
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL stretch_retrig_model k=%0d got=%h want=%h", k, act_vec, exp_vec);
      end
    end
    n_tests++;
    if (ones != 8 + STR) begin
      n_fail++;
      $display("FAIL stretch_retrigger on_cycles=%0d want=%0d", ones, 8 + STR);
    end
`ifdef GPIO_EDGE_COUNT_EN
    n_tests++;
    if (edge_count[7:0] !== 8'd2) begin
      n_fail++;
      $display("FAIL edge_count_two got=%0d want=2", edge_count[7:0]);
    end
    for (int r = 0; r < 254; r++) begin
      gpio_in[0] = 1'b1; repeat (4) tick();
      gpio_in[0] = 1'b0; repeat (4) tick();
    end
    repeat (8) tick();
    n_tests++;
    if (edge_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL edge_count_wrap got=%h want=0000", edge_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mode = 4'b0011;
    gpio_in[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_model k=%0d got=%h want=%h", k, act_vec, exp_vec);
      end
    end
    sys_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if (act_vec !== '0) begin
        n_fail++;
        $display("FAIL rstmid_outputs k=%0d got=%h want=0", k, act_vec);
      end
    end
    sys_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (act_vec !== exp_vec || fall_pulse !== 2'b00) begin
        n_fail++;
        $display("FAIL rstmid_after edge=%0d got=%h want=%h", k, act_vec, exp_vec);
      end
      if (k == 5 || k == 6) begin
        n_tests++;
        if (rise_pulse[0] !== (k == 6)) begin
          n_fail++;
          $display("FAIL rstmid_rise edge=%0d got=%b want=%0d", k, rise_pulse[0], k == 6);
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      sys_rst = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) gpio_in[c] = ~gpio_in[c];
      end
      if ($urandom_range(0, 19) == 0) mode = (2*CH)'($urandom);
      tick();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_model k=%0d got=%h want=%h", k, act_vec, exp_vec);
      end
`ifdef GPIO_EDGE_COUNT_EN
      n_tests++;
      if (edge_count !== {8'(m_ecnt[1]), 8'(m_ecnt[0])}) begin
        n_fail++;
        $display("FAIL random_edge_count k=%0d got=%h", k, edge_count);
      end
`endif
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass_step();
    test_bounce();
    test_toggle();
    test_blink();
    test_stretch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
